led_scheduler_module: RTL and testbench
=======================================

LED_SCHEDULER_MODULE -- requirements
Module: led_scheduler_module

Interface
REQ-001 The block SHALL have parameter T_SLOT, default 23'd5_000_000, giving slot length in CLK cycles (100 ms at 50 MHz); legal range 4..2^23-1.
REQ-002 The block SHALL have parameter ON_START, default 23'd2_750_000, giving the first slot count at which the active LED is lit.
REQ-003 The block SHALL have parameter ON_END, default 23'd3_750_000, giving the first slot count at which the LED is dark again; legal values satisfy ON_START < ON_END <= T_SLOT.
REQ-004 The block SHALL have port CLK, input, 1 bit: system clock, 50 MHz.
REQ-005 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset, sampled on the CLK rising edge.
REQ-006 The block SHALL have port Start, input, 1 bit: level-sampled run request.
REQ-007 The block SHALL have port Stop, input, 1 bit: level-sampled stop request.
REQ-008 The block SHALL have port Mode_Sel, input, 2 bits: 00 shift-up, 01 shift-down, 10 ping-pong, 11 all-blink.
REQ-009 The block SHALL have port Enable_Mask, input, 4 bits: channel participation, bit i = LED i.
REQ-010 The block SHALL have port LED_Out, output, 4 bits: registered LED drive, 1 = lit.
REQ-011 The block SHALL have port Busy, output, 1 bit: high in RUN or STOPPING.
REQ-012 The block SHALL have port Slot_Tick, output, 1 bit: one-cycle pulse at the last cycle of each slot while Busy.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and STOPPING; the slot counter Count is 23 bits wide.
REQ-014 IDLE SHALL go to RUN when Start=1, Stop=0 and Enable_Mask!=0; when Stop=1 or Enable_Mask=0, Start SHALL be ignored.
REQ-015 On the IDLE->RUN edge, Mode_Sel and Enable_Mask SHALL be latched, Count SHALL load 0, and the pointer SHALL load the lowest enabled channel (modes 00, 10; ping-pong direction set to up) or the highest enabled channel (mode 01).
REQ-016 Latched mode and mask SHALL stay constant until the next IDLE->RUN transition; input changes during a run SHALL have no effect.
REQ-017 While Busy, Count SHALL increment by 1 each cycle and wrap from T_SLOT-1 to 0.
REQ-018 Slot_Tick SHALL be 1 exactly on cycles where Busy=1 and Count==T_SLOT-1.
REQ-019 At each wrap in RUN, the pointer SHALL advance as follows:
- mode 00: next higher enabled index, wrapping to the lowest.
- mode 01: next lower enabled index, wrapping to the highest.
- mode 10: next enabled index in the current direction; the direction reverses at the highest and at the lowest enabled index; no end channel repeats.
REQ-020 With exactly one enabled channel, the pointer SHALL stay on that channel in every mode.
REQ-021 LED_Out[i] SHALL be 1 in the cycle after a cycle in which Busy=1, ON_START <= Count < ON_END, and either (mode!=11 and pointer==i) or (mode==11 and latched mask bit i=1); otherwise LED_Out[i] SHALL be 0. This gives one cycle of registered latency.
REQ-022 In RUN, Stop=1 SHALL move the FSM to STOPPING without disturbing Count, the pointer or LED behaviour; Start in RUN or STOPPING SHALL be ignored.
REQ-023 STOPPING SHALL complete the current slot; at Count==T_SLOT-1 it SHALL go to IDLE and clear Count to 0, with no pointer advance.
REQ-024 In IDLE, Count SHALL hold at 0, Busy and Slot_Tick SHALL be 0, and LED_Out SHALL be 0 from the cycle after IDLE is entered.

Reset
REQ-025 RST=1 SHALL, on the next CLK edge, force IDLE, Count=0, pointer=0, direction=up, latched mode=00, latched mask=0, LED_Out=0, Busy=0 and Slot_Tick=0, regardless of state.
REQ-026 RST SHALL take priority over Start and Stop, and reset asserted mid-slot SHALL abort the run with no completion of the current slot.

Verification (T_SLOT=10, ON_START=2, ON_END=6)
REQ-027 The bench SHALL cover: mask=1111, mode 00, one-cycle Start pulse -> LED_Out one-hot 0001,0010,0100,1000,0001; each lit for 4 cycles at Count 3..6; Slot_Tick every 10 cycles.
REQ-028 The bench SHALL cover: mask=1011, mode 10 -> lit channel order 0,1,3,1,0,1,3; channel 2 never lit.
REQ-029 The bench SHALL cover: mask=0110, mode 11 -> LED_Out=0110 for 4 cycles per slot, 0000 otherwise.
REQ-030 The bench SHALL cover: Stop at Count=4 in RUN -> Busy stays 1 through Count=9 and the slot's LED window completes; IDLE follows with LED_Out=0 and no further Slot_Tick.
REQ-031 The bench SHALL cover: Start and Stop high together in IDLE, and Start with mask=0000 -> both ignored; Busy stays 0.
REQ-032 The bench SHALL cover: RST=1 at Count=3 with LED lit -> next cycle LED_Out=0, Busy=0, Count=0; a subsequent Start restarts from the first channel.

Source files
------------

// File: rtl/led_scheduler_module.sv
// Slot-based LED scheduler: steps a lit pointer across enabled channels once per slot,
// lighting it for a fixed window inside each slot, with graceful stop at slot end.
module led_scheduler_module #(
    parameter logic [22:0] T_SLOT   = 23'd5_000_000,
    parameter logic [22:0] ON_START = 23'd2_750_000,
    parameter logic [22:0] ON_END   = 23'd3_750_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       Stop,
    input  logic [1:0] Mode_Sel,
    input  logic [3:0] Enable_Mask,
    output logic [3:0] LED_Out,
    output logic       Busy,
    output logic       Slot_Tick
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_ALL  = 2'b11;

    state_t      state, state_next;
    logic [22:0] count;
    logic [1:0]  ptr, ptr_next;
    logic        dir_up, dir_next;
    logic [1:0]  mode_q;
    logic [3:0]  mask_q;
    logic [3:0]  led_next;
    logic        start_ok, slot_end, in_window;

    function automatic logic [1:0] lowest_en(input logic [3:0] m);
        lowest_en = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) lowest_en = 2'(i);
    endfunction

    function automatic logic [1:0] highest_en(input logic [3:0] m);
        highest_en = 2'd0;
        for (int i = 0; i < 4; i++)
            if (m[i]) highest_en = 2'(i);
    endfunction

    // Nearest enabled channel above/below p, wrapping; p itself when it is the only one.
    function automatic logic [1:0] next_up(input logic [3:0] m, input logic [1:0] p);
        logic [1:0] idx;
        next_up = p;
        for (int k = 3; k >= 1; k--) begin
            idx = p + 2'(k);
            if (m[idx]) next_up = idx;
        end
    endfunction

    function automatic logic [1:0] next_down(input logic [3:0] m, input logic [1:0] p);
        logic [1:0] idx;
        next_down = p;
        for (int k = 3; k >= 1; k--) begin
            idx = p - 2'(k);
            if (m[idx]) next_down = idx;
        end
    endfunction

    assign Busy      = (state != IDLE);
    assign slot_end  = (count == T_SLOT - 23'd1);
    assign Slot_Tick = Busy && slot_end;
    assign in_window = (count >= ON_START) && (count < ON_END);
    assign start_ok  = Start && !Stop && (Enable_Mask != 4'd0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start_ok) state_next = RUN;
            RUN:      if (Stop)     state_next = STOPPING;
            STOPPING: if (slot_end) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        ptr_next = ptr;
        dir_next = dir_up;
        case (mode_q)
            MODE_UP:   ptr_next = next_up(mask_q, ptr);
            MODE_DOWN: ptr_next = next_down(mask_q, ptr);
            MODE_PING: begin
                // Reverse at either end so the end channel is not visited twice in a row.
                if (dir_up) begin
                    if (ptr == highest_en(mask_q)) begin
                        ptr_next = next_down(mask_q, ptr);
                        dir_next = 1'b0;
                    end else begin
                        ptr_next = next_up(mask_q, ptr);
                    end
                end else begin
                    if (ptr == lowest_en(mask_q)) begin
                        ptr_next = next_up(mask_q, ptr);
                        dir_next = 1'b1;
                    end else begin
                        ptr_next = next_down(mask_q, ptr);
                    end
                end
            end
            default: ptr_next = ptr;
        endcase
    end

    always_comb begin
        led_next = 4'd0;
        if (Busy && in_window)
            led_next = (mode_q == MODE_ALL) ? mask_q : (4'b0001 << ptr);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count   <= 23'd0;
            ptr     <= 2'd0;
            dir_up  <= 1'b1;
            mode_q  <= MODE_UP;
            mask_q  <= 4'd0;
            LED_Out <= 4'd0;
        end else begin
            LED_Out <= led_next;
            case (state)
                IDLE: begin
                    count <= 23'd0;
                    if (start_ok) begin
                        mode_q <= Mode_Sel;
                        mask_q <= Enable_Mask;
                        dir_up <= 1'b1;
                        ptr    <= (Mode_Sel == MODE_DOWN) ? highest_en(Enable_Mask)
                                                          : lowest_en(Enable_Mask);
                    end
                end
                RUN: begin
                    count <= slot_end ? 23'd0 : count + 23'd1;
                    if (slot_end) begin
                        ptr    <= ptr_next;
                        dir_up <= dir_next;
                    end
                end
                STOPPING: count <= slot_end ? 23'd0 : count + 23'd1;
                default:  count <= 23'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_led_scheduler_module.sv
// Self-checking bench for led_scheduler_module: directed scenarios plus randomized traffic,
// all checked against a slot/tour-level behavioural model.
module tb_led_scheduler_module;

    localparam int T_I   = 10;
    localparam int ONS_I = 2;
    localparam int ONE_I = 6;

    logic       CLK = 1'b0;
    logic       RST, Start, Stop;
    logic [1:0] Mode_Sel;
    logic [3:0] Enable_Mask;
    logic [3:0] LED_Out;
    logic       Busy, Slot_Tick;

    int errors = 0;
    int checks = 0;

    // Model: run state (0 idle, 1 run, 2 stopping), slot count, position in the channel tour.
    int         m_state = 0;
    int         m_cnt   = 0;
    int         m_pos   = 0;
    int         m_mode  = 0;
    logic [3:0] m_mask  = 4'd0;
    logic [3:0] m_led   = 4'd0;
    int         tour[$];

    led_scheduler_module #(
        .T_SLOT  (23'(T_I)),
        .ON_START(23'(ONS_I)),
        .ON_END  (23'(ONE_I))
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Start      (Start),
        .Stop       (Stop),
        .Mode_Sel   (Mode_Sel),
        .Enable_Mask(Enable_Mask),
        .LED_Out    (LED_Out),
        .Busy       (Busy),
        .Slot_Tick  (Slot_Tick)
    );

    always #5 CLK = ~CLK;

    // Visiting order of channels for one full period of the chosen mode.
    function automatic void build_tour(input logic [3:0] m, input logic [1:0] md);
        int asc[$];
        tour.delete();
        for (int i = 0; i < 4; i++) if (m[i]) asc.push_back(i);
        if (md == 2'b01) begin
            for (int i = asc.size() - 1; i >= 0; i--) tour.push_back(asc[i]);
        end else begin
            foreach (asc[i]) tour.push_back(asc[i]);
            if (md == 2'b10)
                for (int i = asc.size() - 2; i >= 1; i--) tour.push_back(asc[i]);
        end
    endfunction

    function automatic void model_edge();
        if (RST) begin
            m_state = 0; m_cnt = 0; m_pos = 0; m_mode = 0; m_mask = 4'd0; m_led = 4'd0;
            tour.delete();
            return;
        end
        m_led = 4'd0;
        if (m_state != 0 && m_cnt >= ONS_I && m_cnt < ONE_I)
            m_led = (m_mode == 3) ? m_mask : 4'(1 << tour[m_pos]);
        case (m_state)
            0: if (Start && !Stop && Enable_Mask != 4'd0) begin
                build_tour(Enable_Mask, Mode_Sel);
                m_mode = int'(Mode_Sel); m_mask = Enable_Mask;
                m_pos = 0; m_cnt = 0; m_state = 1;
            end
            1: begin
                if (m_cnt == T_I - 1) begin
                    m_cnt = 0;
                    m_pos = (m_pos + 1) % tour.size();
                end else m_cnt++;
                if (Stop) m_state = 2;
            end
            default: begin
                if (m_cnt == T_I - 1) begin m_cnt = 0; m_state = 0; end
                else m_cnt++;
            end
        endcase
    endfunction

    function automatic int idx_of(input logic [3:0] v);
        idx_of = -1;
        for (int i = 0; i < 4; i++) if (v[i]) idx_of = i;
    endfunction

    // Inputs change only on the falling edge; outputs are observed there too.
    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic pulse_start(input logic [1:0] md, input logic [3:0] mk);
        Mode_Sel = md; Enable_Mask = mk; Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic quiesce();
        RST = 1'b1; Start = 1'b0; Stop = 1'b0;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; Start = 1'b1; Stop = 1'b0; Mode_Sel = 2'b10; Enable_Mask = 4'hF;
        step(); step();
        RST = 1'b0; Start = 1'b0;
        checks++; if (LED_Out !== 4'd0) begin errors++; $display("FAIL reset_led got=%b want=0000", LED_Out); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", Busy); end
        checks++; if (Slot_Tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", Slot_Tick); end
        checks++; if (dut.count !== 23'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", dut.count); end
    endtask

    task automatic test_shift_up();
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] prev = 4'd0;
        int ticks = 0, lit = 0;
        pulse_start(2'b00, 4'b1111);
        for (int c = 0; c < 50; c++) begin
            Mode_Sel = 2'($urandom); Enable_Mask = 4'($urandom); Start = 1'($urandom);
            step();
            checks++; if (LED_Out !== m_led) begin errors++; $display("FAIL up_led cyc=%0d got=%b want=%b", c, LED_Out, m_led); end
            checks++; if (Busy !== (m_state != 0)) begin errors++; $display("FAIL up_busy cyc=%0d got=%b", c, Busy); end
            checks++; if (Slot_Tick !== (m_state != 0 && m_cnt == T_I - 1)) begin errors++; $display("FAIL up_tick cyc=%0d got=%b", c, Slot_Tick); end
            if (LED_Out != 4'd0 && prev == 4'd0) order.push_back(idx_of(LED_Out));
            if (LED_Out != 4'd0) lit++;
            if (Slot_Tick) ticks++;
            prev = LED_Out;
        end
        Start = 1'b0;
        checks++; if (order.size() != 5) begin errors++; $display("FAIL up_order_len got=%0d want=5", order.size()); end
        else for (int i = 0; i < 5; i++) begin
            checks++; if (order[i] != exp_order[i]) begin errors++; $display("FAIL up_order[%0d] got=%0d want=%0d", i, order[i], exp_order[i]); end
        end
        checks++; if (lit != 20) begin errors++; $display("FAIL up_lit_cycles got=%0d want=20", lit); end
        checks++; if (ticks != 5) begin errors++; $display("FAIL up_ticks got=%0d want=5", ticks); end
        quiesce();
    endtask

    task automatic test_ping_pong();
        int order[$];
        int exp_order[7] = '{0, 1, 3, 1, 0, 1, 3};
        logic [3:0] prev = 4'd0;
        int ch2 = 0;
        pulse_start(2'b10, 4'b1011);
        for (int c = 0; c < 70; c++) begin
            step();
            checks++; if (LED_Out !== m_led) begin errors++; $display("FAIL pp_led cyc=%0d got=%b want=%b", c, LED_Out, m_led); end
            if (LED_Out != 4'd0 && prev == 4'd0) order.push_back(idx_of(LED_Out));
            if (LED_Out[2]) ch2++;
            prev = LED_Out;
        end
        checks++; if (order.size() != 7) begin errors++; $display("FAIL pp_order_len got=%0d want=7", order.size()); end
        else for (int i = 0; i < 7; i++) begin
            checks++; if (order[i] != exp_order[i]) begin errors++; $display("FAIL pp_order[%0d] got=%0d want=%0d", i, order[i], exp_order[i]); end
        end
        checks++; if (ch2 != 0) begin errors++; $display("FAIL pp_ch2_lit got=%0d want=0", ch2); end
        quiesce();
    endtask

    task automatic test_all_blink();
        int on = 0, bad = 0;
        pulse_start(2'b11, 4'b0110);
        for (int c = 0; c < 30; c++) begin
            step();
            checks++; if (LED_Out !== m_led) begin errors++; $display("FAIL blink_led cyc=%0d got=%b want=%b", c, LED_Out, m_led); end
            if (LED_Out == 4'b0110) on++;
            else if (LED_Out != 4'd0) bad++;
        end
        checks++; if (on != 12) begin errors++; $display("FAIL blink_on_cycles got=%0d want=12", on); end
        checks++; if (bad != 0) begin errors++; $display("FAIL blink_bad_pattern got=%0d want=0", bad); end
        quiesce();
    endtask

    task automatic test_stop_mid_slot();
        int busy_n = 0, lit_n = 0, ticks = 0;
        pulse_start(2'b00, 4'b0101);
        for (int c = 0; c < 4; c++) step();
        checks++; if (dut.count !== 23'd4) begin errors++; $display("FAIL stop_pre_count got=%0d want=4", dut.count); end
        Stop = 1'b1;
        step();
        Stop = 1'b0;
        for (int c = 0; c < 16; c++) begin
            checks++; if (LED_Out !== m_led) begin errors++; $display("FAIL stop_led cyc=%0d got=%b want=%b", c, LED_Out, m_led); end
            checks++; if (Busy !== (m_state != 0)) begin errors++; $display("FAIL stop_busy cyc=%0d got=%b", c, Busy); end
            if (Busy) busy_n++;
            if (LED_Out != 4'd0) lit_n++;
            if (Slot_Tick) ticks++;
            step();
        end
        checks++; if (busy_n != 5) begin errors++; $display("FAIL stop_busy_cycles got=%0d want=5", busy_n); end
        checks++; if (lit_n != 2) begin errors++; $display("FAIL stop_lit_tail got=%0d want=2", lit_n); end
        checks++; if (ticks != 1) begin errors++; $display("FAIL stop_ticks got=%0d want=1", ticks); end
    endtask

    task automatic test_ignored_start();
        Mode_Sel = 2'b00; Enable_Mask = 4'hF; Start = 1'b1; Stop = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ign_startstop_busy cyc=%0d got=%b want=0", c, Busy); end
        end
        Stop = 1'b0; Enable_Mask = 4'd0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ign_nomask_busy cyc=%0d got=%b want=0", c, Busy); end
            checks++; if (LED_Out !== 4'd0) begin errors++; $display("FAIL ign_nomask_led cyc=%0d got=%b want=0000", c, LED_Out); end
        end
        Start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        pulse_start(2'b01, 4'b1111);
        for (int c = 0; c < 3; c++) step();
        checks++; if (LED_Out !== 4'b1000) begin errors++; $display("FAIL rst_prelit got=%b want=1000", LED_Out); end
        RST = 1'b1;
        step();
        RST = 1'b0;
        checks++; if (LED_Out !== 4'd0) begin errors++; $display("FAIL rst_led got=%b want=0000", LED_Out); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", Busy); end
        checks++; if (dut.count !== 23'd0) begin errors++; $display("FAIL rst_count got=%0d want=0", dut.count); end
        pulse_start(2'b01, 4'b1111);
        for (int c = 0; c < 3; c++) step();
        checks++; if (LED_Out !== 4'b1000) begin errors++; $display("FAIL rst_restart_led got=%b want=1000", LED_Out); end
        quiesce();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            RST         = ($urandom_range(0, 299) == 0);
            Start       = ($urandom_range(0, 7) == 0);
            Stop        = ($urandom_range(0, 59) == 0);
            Mode_Sel    = 2'($urandom);
            Enable_Mask = 4'($urandom);
            step();
            checks++; if (LED_Out !== m_led) begin errors++; $display("FAIL rnd_led cyc=%0d got=%b want=%b", c, LED_Out, m_led); end
            checks++; if (Busy !== (m_state != 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b", c, Busy); end
            checks++; if (Slot_Tick !== (m_state != 0 && m_cnt == T_I - 1)) begin errors++; $display("FAIL rnd_tick cyc=%0d got=%b", c, Slot_Tick); end
            checks++; if (dut.count !== 23'(m_cnt)) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", c, dut.count, m_cnt); end
        end
        RST = 1'b0; Start = 1'b0; Stop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_shift_up();
        test_ping_pong();
        test_all_blink();
        test_stop_mid_slot();
        test_ignored_start();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
